// File: rtl/fp32_pkg.sv
// Shared single-precision float definitions for the fp conversion blocks.
// Contents: field widths, exponent bias, all-ones exponent code, and the
// float->int converter state encoding.
package fp32_pkg;

  localparam int unsigned FP32_EXP_W   = 8;
  localparam int unsigned FP32_FRAC_W  = 23;
  localparam int          FP32_BIAS    = 127;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    CONVERT,
    PACK,
    PUT_Z
  } f2i_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational classifier for an IEEE-754 single-precision operand.
// Ports:
//   a               in   32  float operand
//   is_zero_denorm  out  1   exponent field is zero (zero or denormal)
//   is_inf_nan      out  1   exponent field is all ones (Inf or NaN)
//   exp_unbiased    out  10  exponent field minus bias, signed
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]       a,
  output logic              is_zero_denorm,
  output logic              is_inf_nan,
  output logic signed [9:0] exp_unbiased
);

  localparam logic signed [9:0] BiasS = 10'(FP32_BIAS);

  logic [FP32_EXP_W-1:0] exp_field;
  logic                  unused_bits;

  assign exp_field      = a[30:23];
  assign unused_bits    = ^{a[31], a[FP32_FRAC_W-1:0]};
  assign is_zero_denorm = (exp_field == '0);
  assign is_inf_nan     = (exp_field == FP32_EXP_MAX);
  // Zero-extend to 10 bits first so the subtraction never wraps.
  assign exp_unbiased   = $signed({2'b00, exp_field}) - BiasS;

endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single-precision to 32-bit signed integer, truncating toward zero.
// Iterative: the mantissa is shifted right one bit per cycle until the
// exponent reaches 31, so latency depends on the operand.
// Ports:
//   clk           in   1   clock, posedge
//   rst           in   1   synchronous active-high reset
//   input_a       in   32  float operand
//   input_a_stb   in   1   input_a valid
//   input_a_ack   out  1   ready to accept input_a
//   output_z      out  32  integer result
//   output_z_stb  out  1   output_z valid, held until acknowledged
//   output_z_ack  in   1   consumer accepts output_z
module float_to_int
  import fp32_pkg::*;
#(
  parameter logic [31:0] OVF_VALUE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [31:0] IntMin = 32'h8000_0000;
  localparam logic [31:0] FltIntMin = 32'hCF00_0000;

  f2i_state_t state_q, state_d;

  logic [31:0]       a_q, a_d;
  logic              s_q, s_d;
  logic signed [9:0] e_q, e_d;
  logic [31:0]       m_q, m_d;
  logic [31:0]       z_q, z_d;
  logic [31:0]       out_q, out_d;
  logic              ack_q, ack_d;
  logic              stb_q, stb_d;

  logic              is_zero_denorm;
  logic              is_inf_nan;
  logic signed [9:0] exp_unbiased;

  fp32_classify u_classify (
    .a              (a_q),
    .is_zero_denorm (is_zero_denorm),
    .is_inf_nan     (is_inf_nan),
    .exp_unbiased   (exp_unbiased)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      m_q     <= '0;
      z_q     <= '0;
      out_q   <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      e_q     <= e_d;
      m_q     <= m_d;
      z_q     <= z_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GET_A:   if (ack_q && input_a_stb) state_d = UNPACK;
      UNPACK:  state_d = SPECIAL;
      SPECIAL: begin
        if (is_inf_nan || is_zero_denorm || e_q[9] || (a_q == FltIntMin) ||
            (e_q >= 10'sd31)) begin
          state_d = PUT_Z;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: if (e_q == 10'sd31) state_d = PACK;
      PACK:    state_d = PUT_Z;
      PUT_Z:   if (stb_q && output_z_ack) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    s_d   = s_q;
    e_d   = e_q;
    m_d   = m_q;
    z_d   = z_q;
    out_d = out_q;
    ack_d = ack_q;
    stb_d = stb_q;
    unique case (state_q)
      GET_A: begin
        if (ack_q && input_a_stb) begin
          ack_d = 1'b0;
          a_d   = input_a;
        end else begin
          ack_d = 1'b1;
        end
      end
      UNPACK: begin
        s_d = a_q[31];
        e_d = exp_unbiased;
        m_d = {1'b1, a_q[FP32_FRAC_W-1:0], 8'b0};
      end
      SPECIAL: begin
        // Check order matters: Inf/NaN beats zero, -2^31 beats generic overflow.
        if (is_inf_nan) begin
          z_d = OVF_VALUE;
        end else if (is_zero_denorm || e_q[9]) begin
          z_d = '0;
        end else if (a_q == FltIntMin) begin
          z_d = IntMin;
        end else if (e_q >= 10'sd31) begin
          z_d = OVF_VALUE;
        end
      end
      CONVERT: begin
        if (e_q < 10'sd31) begin
          m_d = m_q >> 1;
          e_d = e_q + 10'sd1;
        end
      end
      PACK: begin
        // e <= 30 on entry to CONVERT, so m < 2^31 and negation cannot overflow.
        z_d = s_q ? -m_q : m_q;
      end
      PUT_Z: begin
        if (stb_q && output_z_ack) begin
          stb_d = 1'b0;
        end else begin
          stb_d = 1'b1;
          out_d = z_q;
        end
      end
      default: ;
    endcase
  end

  assign input_a_ack  = ack_q;
  assign output_z     = out_q;
  assign output_z_stb = stb_q;

endmodule

// File: tb/tb_float_to_int.sv
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] OVF = 32'h8000_0000;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  // Independent reference: shift the 24-bit significand directly.
  function automatic logic [31:0] ref_f2i(input logic [31:0] a);
    logic [7:0]  ex;
    int          e;
    logic [31:0] mag;
    ex = a[30:23];
    if (ex == 8'hFF) return OVF;
    if (ex < 8'd127) return 32'h0;
    if (a == 32'hCF00_0000) return 32'h8000_0000;
    e = int'(ex) - 127;
    if (e >= 31) return OVF;
    mag = {8'h00, 1'b1, a[22:0]};
    if (e >= 23) mag = mag << (e - 23);
    else mag = mag >> (23 - e);
    return a[31] ? -mag : mag;
  endfunction

  // Drives one transaction; reports result, latency and timeout. No checking here.
  task automatic run_op(input logic [31:0] a, input int idle, input int ack_dly,
                        output logic [31:0] z, output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = -1;
    z   = 'x;
    repeat (idle) @(posedge clk);
    #1;
    input_a     = a;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      to = 1'b1;
      input_a_stb = 1'b0;
      return;
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = $urandom;
    n = 0;
    while (!output_z_stb && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      to = 1'b1;
      return;
    end
    lat = n;
    z   = output_z;
    repeat (ack_dly) @(posedge clk);
    #1;
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ack=%b stb=%b z=%h, required ack=0 stb=0 z=0",
               input_a_ack, output_z_stb, output_z);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_ack_rise: ack=%b, required 1", input_a_ack);
    end
  endtask

  logic [31:0] norm_in  [4] = '{32'h3FC0_0000, 32'hBFC0_0000, 32'h42F6_E979, 32'h4EFF_FFFF};
  logic [31:0] norm_exp [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_007B, 32'h7FFF_FF80};
  int          norm_lat [4] = '{36, 36, 30, 6};

  task automatic test_normal();
    logic [31:0] z;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(norm_in[i], 0, 0, z, lat, to);
      checks++;
      if (to || z !== norm_exp[i]) begin
        errors++;
        $display("FAIL normal_value[%h]: got %h timeout=%0d, required %h",
                 norm_in[i], z, to, norm_exp[i]);
      end
      checks++;
      if (lat != norm_lat[i]) begin
        errors++;
        $display("FAIL normal_latency[%h]: got %0d, required %0d", norm_in[i], lat, norm_lat[i]);
      end
    end
  endtask

  logic [31:0] spec_in  [7] = '{32'h3F00_0000, 32'h8000_0000, 32'h0000_0001, 32'h7FC0_0000,
                                32'hFF80_0000, 32'h4F00_0000, 32'hCF00_0000};
  logic [31:0] spec_exp [7] = '{32'h0, 32'h0, 32'h0, OVF, OVF, OVF, 32'h8000_0000};

  task automatic test_special();
    logic [31:0] z;
    int lat;
    bit to;
    for (int i = 0; i < 7; i++) begin
      run_op(spec_in[i], 1, 1, z, lat, to);
      checks++;
      if (to || z !== spec_exp[i]) begin
        errors++;
        $display("FAIL special_value[%h]: got %h timeout=%0d, required %h",
                 spec_in[i], z, to, spec_exp[i]);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL special_latency[%h]: got %0d, required 3", spec_in[i], lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    #1;
    input_a     = 32'h3F80_0000;  // 1.0
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    n = 0;
    while (!output_z_stb && n < 100) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (output_z_stb !== 1'b1 || output_z !== 32'h1 || input_a_ack !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: stb=%b z=%h ack=%b, required stb=1 z=1 ack=0",
                 i, output_z_stb, output_z, input_a_ack);
      end
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
      errors++;
      $display("FAIL release: stb=%b ack=%b, required stb=0 ack=0", output_z_stb, input_a_ack);
    end
    @(posedge clk); #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_after_release: ack=%b, required 1", input_a_ack);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, z, exp_z;
    int lat;
    bit to;
    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      // Bias half the operands into the convertible/overflow exponent band.
      if (i % 2 == 0) a[30:23] = 8'(110 + $urandom_range(0, 55));
      exp_z = ref_f2i(a);
      run_op(a, $urandom_range(0, 2), $urandom_range(0, 3), z, lat, to);
      checks++;
      if (to || z !== exp_z) begin
        errors++;
        $display("FAIL random[%0d] a=%h: got %h timeout=%0d, required %h", i, a, z, to, exp_z);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] z;
    int lat, n;
    bit to;
    #1;
    input_a     = 32'h3FC0_0000;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: stb=%b ack=%b, required stb=0 ack=0", output_z_stb, input_a_ack);
    end
    run_op(32'h42F6_E979, 0, 0, z, lat, to);
    checks++;
    if (to || z !== 32'h0000_007B) begin
      errors++;
      $display("FAIL after_reset_value: got %h timeout=%0d, required 0000007b", z, to);
    end
    checks++;
    if (lat != 30) begin
      errors++;
      $display("FAIL after_reset_latency: got %0d, required 30", lat);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
